axil_reg_master: RTL and testbench
==================================

Name: axil_reg_master

Overview:
- AXI4-Lite initiator for the datapath register file: turns one command at a time into one AXI4-Lite single-beat read or write.
- Returns the read data and response to the requester.
- Sits between on-chip control logic (bring-up sequencer, debug bridge) and the regfile slave port.
- Adds a transaction timeout so a hung slave cannot stall the requester forever.

Parameters:
- DATA_WIDTH, 32, AXI data width.
- ADDR_WIDTH, 32, AXI address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 1024, cycles from first AXI valid to B/R handshake before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  STRB_WIDTH  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response produced by timeout
- busy  out  1  high in every state except IDLE
- m_axil_awaddr/awprot/awvalid/awready, m_axil_wdata/wstrb/wvalid/wready, m_axil_bresp/bvalid/bready, m_axil_araddr/arprot/arvalid/arready, m_axil_rdata/rresp/rvalid/rready  standard AXI4-Lite master widths; awprot = arprot = 3'b000.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. rst mid-transaction drops every valid/ready on the next edge and discards the transaction.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, ERROR.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register addr/wdata/wstrb and go to WR_REQ or RD_REQ.
  - Request valids rise the cycle after acceptance.
- WR_REQ:
  - awvalid and wvalid rise together.
  - Each drops the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: bready = 1; on the bvalid handshake, capture bresp and go to RSP.
- RD_REQ: arvalid held until the arready handshake, then RD_RESP.
- RD_RESP: rready = 1; on the rvalid handshake, capture rdata and rresp and go to RSP.
- RSP: rsp_valid = 1, held with stable payload until rsp_ready, then IDLE. A new cmd is accepted no earlier than the cycle after that handshake.
- Latency:
  - rsp_valid rises the cycle after the B/R handshake.
  - With a zero-wait slave (ready already high, response on the cycle after the request handshake), a read takes 3 cycles from cmd acceptance to rsp_valid and a write takes 3 cycles.
- Valids are never deasserted before their handshake, including on timeout. AXI payloads stay stable while valid.
- Timeout counter:
  - Clears on cmd acceptance.
  - Increments each cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - When it reaches TIMEOUT_CYCLES, go to RSP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - After that response is consumed, go to ERROR, not IDLE.
- ERROR:
  - cmd_ready = 0, busy = 1; sticky until rst.
  - Any still-pending aw/w/ar valid stays asserted until its handshake.
  - bready/rready stay 1 so late responses are drained and discarded.
- A B/R handshake in the same cycle the counter hits the limit counts as success, not timeout.
- Counter width is clog2(TIMEOUT_CYCLES+1) and it saturates; with TIMEOUT_CYCLES = 0 it is never compared.
- SLVERR/DECERR from the slave is passed through in rsp_resp with rsp_timeout = 0 and is not an error state.

Test Plan:
- Write addr 0x50 data 0x1234 strb 0xF, zero-wait slave -> one AW/W beat with those values; rsp_resp=0, rsp_timeout=0; rsp_valid 3 cycles after accept.
- Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid held 5 cycles with stable addr; single B accepted.
- Read addr 0x28, slave returns 0xDEADBEEF with RRESP=0 after 2 wait cycles -> rsp_rdata=0xDEADBEEF; rsp_valid held 3 cycles while rsp_ready=0 with stable payload.
- Read with TIMEOUT_CYCLES=16, slave never raises rvalid -> rsp_valid with rsp_timeout=1, rsp_resp=2'b10, rdata=0; then cmd_ready stays 0 until rst; a late rvalid is consumed silently.
- Slave returns BRESP=2'b11 -> rsp_resp=2'b11, rsp_timeout=0; next cmd accepted.
- Assert rst while awvalid is high -> next cycle all valids 0, busy=0, cmd_ready=1.

Source files
------------

// File: rtl/axil_reg_master.sv
// AXI4-Lite initiator: one command becomes one single-beat read or write, with a
// response handshake back to the requester and a sticky abort on slave timeout.
`timescale 1ns/1ps
module axil_reg_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP, S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  tmo_q, tmo_d;
    logic                  in_flight, tmo_hit, b_hs, r_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        // Request valids live outside the state machine so they survive an abort
        awvalid_d = awvalid_q & ~m_axil_awready;
        wvalid_d  = wvalid_q & ~m_axil_wready;
        arvalid_d = arvalid_q & ~m_axil_arready;

        in_flight = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                    (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);
        b_hs      = m_axil_bvalid && m_axil_bready;
        r_hs      = m_axil_rvalid && m_axil_rready;

        if (in_flight && (cnt_q != CNT_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    cnt_d   = '0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (!awvalid_d && !wvalid_d) state_d = S_WR_RESP;
                else if (tmo_hit)            state_d = S_RSP;
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    rdata_d = '0;
                    resp_d  = m_axil_bresp;
                    tmo_d   = 1'b0;
                    state_d = S_RSP;
                end else if (tmo_hit) begin
                    state_d = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (!arvalid_d)   state_d = S_RD_RESP;
                else if (tmo_hit) state_d = S_RSP;
            end
            S_RD_RESP: begin
                if (r_hs) begin
                    rdata_d = m_axil_rdata;
                    resp_d  = m_axil_rresp;
                    tmo_d   = 1'b0;
                    state_d = S_RSP;
                end else if (tmo_hit) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = tmo_q ? S_ERROR : S_IDLE;
            end
            default: state_d = S_ERROR;
        endcase

        // Abort payload overrides whatever the in-flight branch selected
        if (in_flight && (state_d == S_RSP) && !b_hs && !r_hs) begin
            rdata_d = '0;
            resp_d  = 2'b10;
            tmo_d   = 1'b1;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign rsp_valid      = (state_q == S_RSP);
    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;
    assign rsp_timeout    = tmo_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = (state_q == S_WR_RESP) || (state_q == S_ERROR);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = (state_q == S_RD_RESP) || (state_q == S_ERROR);

endmodule

// File: tb/tb_axil_reg_master.sv
// Directed bench for axil_reg_master: bench acts as requester and as AXI4-Lite slave.
`timescale 1ns/1ps
module tb_axil_reg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axil_reg_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_valids got=%b want=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
    endtask

    task automatic test_write_zero_wait();
        awready = 1'b1; wready = 1'b1;
        issue(1'b1, 32'h50, 32'h1234, 4'hF);
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr0_valids got=%b want=11", {awvalid, wvalid}); end
        checks++; if ({awaddr, wdata, wstrb, awprot} !== {32'h50, 32'h1234, 4'hF, 3'b000}) begin
            errors++; $display("FAIL wr0_payload got=%h/%h/%h/%h want=50/1234/f/0", awaddr, wdata, wstrb, awprot); end
        tick();
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr0_after_hs got=%b want=001", {awvalid, wvalid, bready}); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr0_early_rsp got=%b want=0", rsp_valid); end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checks++; if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b00, 1'b0, 32'h0}) begin
            errors++; $display("FAIL wr0_rsp got=%b/%b/%b/%h want=1/00/0/0", rsp_valid, rsp_resp, rsp_timeout, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL wr0_idle got=%b want=01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_write_aw_delay();
        awready = 1'b0; wready = 1'b1;
        issue(1'b1, 32'h60, 32'hCAFE0001, 4'h3);
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) awready = 1'b1;
            checks++; if ({awvalid, awaddr} !== {1'b1, 32'h60}) begin
                errors++; $display("FAIL wrd_aw_hold cyc=%0d got=%b/%h want=1/60", c, awvalid, awaddr); end
            checks++; if (wvalid !== (c == 1)) begin
                errors++; $display("FAIL wrd_w cyc=%0d got=%b want=%b", c, wvalid, (c == 1)); end
            tick();
        end
        awready = 1'b1;
        checks++; if ({awvalid, bready} !== 2'b01) begin errors++; $display("FAIL wrd_resp_phase got=%b want=01", {awvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        checks++; if ({rsp_valid, bready, rsp_resp} !== {1'b1, 1'b0, 2'b00}) begin
            errors++; $display("FAIL wrd_single_b got=%b/%b/%b want=1/0/00", rsp_valid, bready, rsp_resp); end
        bvalid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_wait();
        arready = 1'b1;
        issue(1'b0, 32'h28, 32'h0, 4'h0);
        checks++; if ({arvalid, araddr, arprot} !== {1'b1, 32'h28, 3'b000}) begin
            errors++; $display("FAIL rd_ar got=%b/%h/%h want=1/28/0", arvalid, araddr, arprot); end
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++; if ({arvalid, rready, rsp_valid} !== 3'b010) begin
                errors++; $display("FAIL rd_wait cyc=%0d got=%b want=010", c, {arvalid, rready, rsp_valid}); end
            tick();
        end
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            checks++; if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b0}) begin
                errors++; $display("FAIL rd_rsp_hold cyc=%0d got=%b/%h/%b/%b want=1/deadbeef/00/0", c, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rd_idle got=%b want=01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_back_to_back_slverr();
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        issue(1'b1, 32'h70, 32'h5A5A5A5A, 4'hC);
        tick();
        bvalid = 1'b1; bresp = 2'b11;
        tick();
        bvalid = 1'b0;
        checks++; if ({rsp_valid, rsp_resp, rsp_timeout} !== {1'b1, 2'b11, 1'b0}) begin
            errors++; $display("FAIL slverr_rsp got=%b/%b/%b want=1/11/0", rsp_valid, rsp_resp, rsp_timeout); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL slverr_next_ready got=%b want=1", cmd_ready); end
        issue(1'b0, 32'h74, 32'h0, 4'h0);
        checks++; if ({arvalid, araddr} !== {1'b1, 32'h74}) begin errors++; $display("FAIL b2b_ar got=%b/%h want=1/74", arvalid, araddr); end
        tick();
        rvalid = 1'b1; rdata = 32'h11223344; rresp = 2'b01;
        tick();
        rvalid = 1'b0;
        checks++; if ({rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, 32'h11223344, 2'b01}) begin
            errors++; $display("FAIL b2b_rsp got=%b/%h/%b want=1/11223344/01", rsp_valid, rsp_rdata, rsp_resp); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        awready = 1'b0; wready = 1'b0;
        issue(1'b1, 32'h80, 32'h1, 4'h1);
        checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL rstmid_aw_up got=%b want=1", awvalid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({awvalid, wvalid, arvalid, busy, cmd_ready} !== 5'b00001) begin
            errors++; $display("FAIL rstmid_state got=%b want=00001", {awvalid, wvalid, arvalid, busy, cmd_ready}); end
    endtask

    task automatic test_timeout();
        int n;
        arready = 1'b1;
        issue(1'b0, 32'h90, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n < 16 || n > 18) begin errors++; $display("FAIL tmo_latency got=%0d want=16..18", n); end
        checks++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {1'b1, 1'b1, 2'b10, 32'h0}) begin
            errors++; $display("FAIL tmo_rsp got=%b/%b/%b/%h want=1/1/10/0", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if ({cmd_ready, busy, rready, rsp_valid} !== 4'b0110) begin
            errors++; $display("FAIL tmo_error_state got=%b want=0110", {cmd_ready, busy, rready, rsp_valid}); end
        rvalid = 1'b1; rdata = 32'hBAD0BAD0; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h94;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({cmd_ready, rsp_valid, arvalid, busy} !== 4'b0001) begin
                errors++; $display("FAIL tmo_sticky cyc=%0d got=%b want=0001", c, {cmd_ready, rsp_valid, arvalid, busy}); end
            tick();
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL tmo_rst_clears got=%b want=10", {cmd_ready, busy}); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        test_reset();
        test_write_zero_wait();
        test_write_aw_delay();
        test_read_wait();
        test_back_to_back_slverr();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
